// File: rtl/ifetch_queue_pkg.sv
// ifetch_queue_pkg: shared instruction-fetch constants
package ifetch_queue_pkg;
    localparam int ILEN = 32;
    localparam int INSTR_BYTES = 4;
    localparam logic [ILEN-1:0] NOP = 32'h0000_0013;
endpackage

// File: rtl/ifetch_queue_fifo_sync.sv
// fifo_sync: synchronous FIFO with flush, power-of-two depth
module fifo_sync #(
    parameter int DATA_W = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DATA_W-1:0]          wdata,
    output logic [DATA_W-1:0]          rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    assign rdata = mem[rp];
    assign full = count == CW'(DEPTH);
    assign empty = count == '0;
    always_ff @(posedge clk)
        if (push && !(rst || flush)) mem[wp] <= wdata;
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wp <= '0;
            rp <= '0;
            count <= '0;
        end else begin
            if (push) wp <= wp + AW'(1);
            if (pop) rp <= rp + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: rtl/ifetch_queue.sv
// ifetch_queue: instruction prefetch with credit-based SRAM requests and redirect flush
module ifetch_queue
    import ifetch_queue_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    output logic [XLEN-1:0]            imem_addr,
    output logic                       imem_ren,
    input  logic [ILEN-1:0]            imem_rdata,
    input  logic                       redirect_valid,
    input  logic [XLEN-1:0]            redirect_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ILEN-1:0]            out_instr,
    output logic [XLEN-1:0]            out_pc,
    output logic [XLEN-1:0]            out_pc_plus4,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int CW = $clog2(DEPTH+1);
    logic [XLEN-1:0] fetch_pc, req_pc;
    logic inflight, issue, push, pop, empty, full;
    logic [ILEN+XLEN-1:0] head;
    logic [CW:0] credit;
    logic [ILEN-1:0] head_instr;
    assign out_valid = !empty && !redirect_valid && !rst;
    assign pop = out_valid && out_ready;
    // Occupancy including the response still on its way from the SRAM
    assign credit = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
    assign issue = enable && !redirect_valid && !rst && credit < (CW+1)'(DEPTH);
    assign push = inflight && !redirect_valid && (!full || pop);
    assign imem_ren = issue;
    assign imem_addr = rst ? RESET_PC : fetch_pc;
    assign {head_instr, out_pc} = head;
    assign out_instr = out_valid ? head_instr : NOP;
    assign out_pc_plus4 = out_pc + XLEN'(INSTR_BYTES);
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            inflight <= 1'b0;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc & ~XLEN'(3);
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                fetch_pc <= fetch_pc + XLEN'(INSTR_BYTES);
                req_pc <= fetch_pc;
            end
        end
    end
    fifo_sync #(.DATA_W(ILEN+XLEN), .DEPTH(DEPTH)) u_fifo (
        .clk(clk),
        .rst(rst),
        .flush(redirect_valid),
        .push(push),
        .pop(pop),
        .wdata({imem_rdata, req_pc}),
        .rdata(head),
        .full(full),
        .empty(empty),
        .count(count)
    );
endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: directed + random stimulus against a queue-based fetch model
module tb_ifetch_queue;
    localparam int XLEN = 64;
    localparam int DEPTH = 4;
    localparam logic [63:0] RESET_PC = 64'h0;
    logic clk, rst, enable, imem_ren, redirect_valid, out_valid, out_ready;
    logic [63:0] imem_addr, redirect_pc, out_pc, out_pc_plus4;
    logic [31:0] imem_rdata, out_instr;
    logic [2:0] count;
    int n_cmp = 0, n_bad = 0;
    typedef struct {logic [31:0] instr; logic [63:0] pc;} ent_t;
    ent_t q[$];
    bit m_inf;
    logic [63:0] m_req, m_fpc, nxt_pc;

    ifetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst), .enable(enable), .imem_addr(imem_addr), .imem_ren(imem_ren),
        .imem_rdata(imem_rdata), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
        .out_pc_plus4(out_pc_plus4), .count(count)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [63:0] a);
        return 32'h100 + a[33:2];
    endfunction

    initial imem_rdata = 0;
    always @(posedge clk) if (imem_ren) imem_rdata <= word(imem_addr);

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic e, input logic rv, input logic [63:0] rp, input logic rd);
        bit ev, ei, pop;
        int occ;
        @(negedge clk);
        rst = r; enable = e; redirect_valid = rv; redirect_pc = rp; out_ready = rd;
        #1;
        ev = q.size() > 0 && !r && !rv;
        pop = ev && rd;
        occ = q.size() + int'(m_inf) - int'(pop);
        ei = !r && e && !rv && occ < DEPTH;
        chk("out_valid", 64'(out_valid), 64'(ev));
        chk("imem_ren", 64'(imem_ren), 64'(ei));
        chk("imem_addr", imem_addr, r ? RESET_PC : m_fpc);
        chk("count", 64'(count), 64'(q.size()));
        if (ev) begin
            chk("out_pc", out_pc, q[0].pc);
            chk("out_instr", 64'(out_instr), 64'(q[0].instr));
            chk("out_pc_plus4", out_pc_plus4, q[0].pc + 64'd4);
        end
        if (pop) begin
            chk("seq_pc", out_pc, nxt_pc);
            nxt_pc += 64'd4;
        end
        @(posedge clk);
        if (r) begin
            q.delete(); m_inf = 0; m_fpc = RESET_PC; nxt_pc = RESET_PC;
        end else if (rv) begin
            q.delete(); m_inf = 0; m_fpc = rp & ~64'd3; nxt_pc = rp & ~64'd3;
        end else begin
            if (pop) void'(q.pop_front());
            if (m_inf) q.push_back('{word(m_req), m_req});
            m_inf = ei;
            if (ei) begin
                m_req = m_fpc;
                m_fpc += 64'd4;
            end
        end
    endtask

    initial begin
        rst = 1; enable = 0; redirect_valid = 0; redirect_pc = 0; out_ready = 0;
        m_inf = 0; m_req = 0; m_fpc = RESET_PC; nxt_pc = RESET_PC;
        repeat (2) @(posedge clk);
        repeat (2) step(1, 1, 0, 0, 1);
        repeat (12) step(0, 1, 0, 0, 1);
        repeat (10) step(0, 1, 0, 0, 0);
        repeat (6) step(0, 1, 0, 0, 1);
        repeat (3) step(0, 1, 0, 0, 0);
        step(0, 1, 1, 64'h43, 1);
        repeat (5) step(0, 1, 0, 0, 1);
        repeat (5) step(0, 0, 0, 0, 1);
        repeat (3) step(0, 1, 0, 0, 1);
        step(0, 1, 1, 64'hFFFF_FFFF_FFFF_FFF8, 1);
        repeat (6) step(0, 1, 0, 0, 1);
        step(0, 1, 1, 64'h200, 1);
        step(0, 1, 1, 64'h305, 1);
        repeat (4) step(0, 1, 0, 0, 1);
        repeat (3) step(0, 1, 0, 0, 0);
        step(1, 1, 0, 0, 1);
        repeat (4) step(0, 1, 0, 0, 1);
        for (int i = 0; i < 2000; i++) begin
            logic [63:0] rp;
            rp = ($urandom_range(0, 3) == 0) ? (64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15)))
                                             : {32'($urandom), 32'($urandom)};
            step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 80,
                 $urandom_range(0, 99) < 5, rp, $urandom_range(0, 99) < 65);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ifetch_queue.md
IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 Parameter XLEN, default 64, PC and address width in bits.
REQ-002 Parameter DEPTH, default 4, prefetch queue entries; power of two, minimum 2.
REQ-003 Parameter RESET_PC, default 0, fetch address after reset.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 enable  input  1  fetch permitted; low blocks new memory requests only.
REQ-007 imem_addr  output  XLEN  byte address of current request to instruction SRAM.
REQ-008 imem_ren  output  1  request strobe; SRAM returns data exactly one cycle later.
REQ-009 imem_rdata  input  32  SRAM read data, valid the cycle after imem_ren.
REQ-010 redirect_valid  input  1  branch/jump taken; flush and refetch.
REQ-011 redirect_pc  input  XLEN  new fetch address; bits [1:0] ignored (treated as 0).
REQ-012 out_valid  output  1  head entry available to decode.
REQ-013 out_ready  input  1  decode accepts head entry; transfer when out_valid and out_ready.
REQ-014 out_instr  output  32  head instruction.
REQ-015 out_pc  output  XLEN  address of head instruction.
REQ-016 out_pc_plus4  output  XLEN  out_pc + 4, modulo 2^XLEN.
REQ-017 count  output  clog2(DEPTH+1)  current queue occupancy.

Function
REQ-018 Queue SHALL be FIFO of {instr, pc}; out_* SHALL reflect head entry; out_instr/out_pc are don't-care when out_valid low.
REQ-019 Request SHALL issue (imem_ren=1, imem_addr=fetch_pc) when enable=1, redirect_valid=0 and count + inflight - pop < DEPTH, where inflight is the one-bit registered prior request and pop is the current-cycle transfer.
REQ-020 On each issued request fetch_pc SHALL advance by 4, wrapping modulo 2^XLEN.
REQ-021 A non-squashed in-flight response SHALL be written to the queue tail the cycle it arrives; out_valid for it SHALL rise one cycle later (2 cycles request-to-out_valid).
REQ-022 With out_ready held high and enable high the block SHALL sustain one transfer per cycle for every DEPTH >= 2.
REQ-023 Simultaneous push and pop SHALL leave count unchanged; push when full SHALL be impossible by REQ-019 credit rule.
REQ-024 redirect_valid=1 SHALL: clear queue (count=0 next cycle), force out_valid=0 in that cycle (no transfer), suppress imem_ren, squash any in-flight response, load fetch_pc with {redirect_pc[XLEN-1:2],2'b00}.
REQ-025 First request after redirect SHALL issue the next cycle at the redirect address if enable=1.
REQ-026 Redirect SHALL take priority over push, pop and issue in the same cycle.
REQ-027 enable=0 SHALL not discard an in-flight response and SHALL not block pops.
REQ-028 Back-to-back redirects SHALL each take effect; only the last address is fetched.

Reset
REQ-029 While rst=1 at a clock edge: fetch_pc=RESET_PC, queue empty, count=0, inflight=0.
REQ-030 During and after reset until first request: out_valid=0, imem_ren=0, imem_addr=RESET_PC.
REQ-031 Reset mid-operation SHALL discard queue contents and any in-flight response; first request issues the cycle after rst deasserts.

Structure
REQ-032 Shared package SHALL hold ILEN (32), instruction byte stride (4) and the NOP encoding 32'h00000013.
REQ-033 Queue SHALL be a separate sub-module fifo_sync (parameters DATA_W, DEPTH; push/pop/flush, full/empty/count); pointer and PC logic stay in ifetch_queue.
REQ-034 Target size 120-400 lines of RTL total; no asynchronous logic.

Verification
REQ-035 Reset release, enable=1, out_ready=1, SRAM words 0..7 = 0x100+i -> imem_ren high from cycle 0, out_valid from cycle 2, out_pc 0,4,8,... one per cycle, out_instr 0x100,0x101,...
REQ-036 out_ready=0 for 10 cycles, DEPTH=4 -> count saturates at 4, imem_ren low once count+inflight=4, no entry lost; resume yields contiguous PCs.
REQ-037 redirect_valid with redirect_pc=0x43 while queue holds 3 entries and request in flight -> next cycle count=0, out_valid=0; following request imem_addr=0x40; first out_pc=0x40.
REQ-038 enable dropped for 5 cycles with request in flight -> that response enqueued, no further imem_ren, pops continue until empty.
REQ-039 fetch_pc at 2^XLEN-4 -> next imem_addr=0, out_pc_plus4=0 for the wrapped entry.
REQ-040 rst asserted with 2 queued entries and a request in flight -> out_valid=0, count=0, next imem_addr=RESET_PC; stale data never appears on out_instr with out_valid=1.
